// File: rtl/mskand_rnd_feeder_pkg.sv
// Shared sizing helpers and packer state type for the HPC2 randomness feeder.
package mskand_rnd_feeder_pkg;

   localparam int DEFAULT_SHARES = 2;

   typedef enum logic [0:0] {
      PK_FILL = 1'b0,
      PK_HOLD = 1'b1
   } pk_state_e;

   function automatic int hpc2rnd(input int shares);
      return (shares * (shares - 1)) / 2;
   endfunction

   function automatic int calc_out_w(input int shares, input int ngadgets);
      return ngadgets * hpc2rnd(shares);
   endfunction

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mskand_rnd_feeder_if.sv
// PRNG-side stream, gadget-side word bus and status of the randomness feeder.
interface mskand_rnd_feeder_if #(
   parameter int IN_W  = 2,
   parameter int OUT_W = 4,
   parameter int LVL_W = 3
);
   logic [IN_W-1:0]  in_rnd;
   logic             in_valid;
   logic             in_ready;
   logic [OUT_W-1:0] out_rnd;
   logic             out_valid;
   logic             out_take;
   logic [LVL_W-1:0] level;
   logic             err_underflow;

   modport slave (
      input  in_rnd, in_valid, out_take,
      output in_ready, out_rnd, out_valid, level, err_underflow
   );

   modport master (
      output in_rnd, in_valid, out_take,
      input  in_ready, out_rnd, out_valid, level, err_underflow
   );
endinterface

// File: rtl/mskand_rnd_fifo.sv
// DEPTH x W FIFO that erases each entry as it is popped, so used randomness
// never lingers in storage; also flags pops requested while empty.
module mskand_rnd_fifo
   import mskand_rnd_feeder_pkg::*;
#(
   parameter  int W     = 4,
   parameter  int DEPTH = 4,
   localparam int AW    = clog2(DEPTH),
   localparam int LVL_W = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             i_push,
   input  logic [W-1:0]     i_push_data,
   input  logic             i_take,
   output logic [W-1:0]     o_head,
   output logic             o_valid,
   output logic [LVL_W-1:0] o_level,
   output logic             o_underflow
);

   logic [W-1:0]     r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [LVL_W-1:0] r_level;
   logic             r_underflow;

   logic w_valid;
   logic w_pop;
   logic w_push;

   assign w_valid = (r_level != {LVL_W{1'b0}});
   assign w_pop   = i_take & w_valid;
   assign w_push  = i_push & ((r_level != LVL_W'(DEPTH)) | w_pop);

   // When full, push and pop hit the same slot: the erase is overridden by the new word.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {W{1'b0}};
         end
      end else begin
         if (w_pop) begin
            r_mem[r_rptr] <= {W{1'b0}};
         end
         if (w_push) begin
            r_mem[r_wptr] <= i_push_data;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wptr      <= {AW{1'b0}};
         r_rptr      <= {AW{1'b0}};
         r_level     <= {LVL_W{1'b0}};
         r_underflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
         if (i_take & ~w_valid) begin
            r_underflow <= 1'b1;
         end
      end
   end

   always_comb begin
      if (w_valid) begin
         o_head = r_mem[r_rptr];
      end else begin
         o_head = {W{1'b0}};
      end
   end

   assign o_valid     = w_valid;
   assign o_level     = r_level;
   assign o_underflow = r_underflow;

endmodule

// File: rtl/mskand_rnd_feeder.sv
// Packs narrow PRNG beats into HPC2 gadget-array rnd words and hands each
// word out exactly once through an erase-on-pop FIFO.
module mskand_rnd_feeder
   import mskand_rnd_feeder_pkg::*;
#(
   parameter int d        = DEFAULT_SHARES,
   parameter int NGADGETS = 4,
   parameter int IN_W     = 2,
   parameter int DEPTH    = 4
) (
   input  logic                 clk,
   input  logic                 nrst,
   mskand_rnd_feeder_if.slave   bus
);

   localparam int OUT_W = calc_out_w(d, NGADGETS);
   localparam int K     = OUT_W / IN_W;
   localparam int CW    = (K > 1) ? clog2(K) : 1;
   localparam int LVL_W = clog2(DEPTH + 1);

   generate
      if ((OUT_W % IN_W) != 0) begin : g_bad_width
         $error("mskand_rnd_feeder: OUT_W must be a multiple of IN_W");
      end
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("mskand_rnd_feeder: DEPTH must be a power of two >= 2");
      end
   endgenerate

   pk_state_e        r_state;
   pk_state_e        w_state_nxt;
   logic [OUT_W-1:0] r_pack;
   logic [OUT_W-1:0] w_pack_nxt;
   logic [OUT_W-1:0] w_word;
   logic [OUT_W-1:0] w_push_data;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [LVL_W-1:0] w_level;
   logic             w_accept;
   logic             w_cnt_last;
   logic             w_room;
   logic             w_push;

   assign bus.in_ready = nrst & (r_state == PK_FILL);
   assign w_accept     = bus.in_valid & bus.in_ready;
   assign w_cnt_last   = (r_cnt == CW'(K - 1));
   assign w_room       = (w_level != LVL_W'(DEPTH)) | bus.out_take;
   assign bus.level    = w_level;

   // Packed word as it stands once the current beat lands in its slot.
   always_comb begin
      w_word = r_pack;
      for (int i = 0; i < K; i++) begin
         if (r_cnt == CW'(i)) begin
            w_word[i*IN_W +: IN_W] = bus.in_rnd;
         end else begin
            w_word[i*IN_W +: IN_W] = r_pack[i*IN_W +: IN_W];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pack_nxt  = r_pack;
      w_cnt_nxt   = r_cnt;
      w_push      = 1'b0;
      w_push_data = r_pack;
      case (r_state)
         PK_FILL: begin
            if (w_accept) begin
               w_pack_nxt = w_word;
               if (w_cnt_last) begin
                  w_cnt_nxt = {CW{1'b0}};
                  if (w_room) begin
                     w_push      = 1'b1;
                     w_push_data = w_word;
                     w_pack_nxt  = {OUT_W{1'b0}};
                  end else begin
                     w_state_nxt = PK_HOLD;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end else begin
               w_state_nxt = PK_FILL;
            end
         end
         PK_HOLD: begin
            if (w_room) begin
               w_push      = 1'b1;
               w_push_data = r_pack;
               w_pack_nxt  = {OUT_W{1'b0}};
               w_state_nxt = PK_FILL;
            end else begin
               w_state_nxt = PK_HOLD;
            end
         end
         default: begin
            w_state_nxt = PK_FILL;
            w_pack_nxt  = {OUT_W{1'b0}};
            w_cnt_nxt   = {CW{1'b0}};
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= PK_FILL;
         r_pack  <= {OUT_W{1'b0}};
         r_cnt   <= {CW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_pack  <= w_pack_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   mskand_rnd_fifo #(
      .W     (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .nrst        (nrst),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_take      (bus.out_take),
      .o_head      (bus.out_rnd),
      .o_valid     (bus.out_valid),
      .o_level     (w_level),
      .o_underflow (bus.err_underflow)
   );

endmodule

// File: tb/tb_mskand_rnd_feeder.sv
// Bench for mskand_rnd_feeder: a queue-level model checks the d=2 instance every
// cycle; a beat/word scoreboard checks a d=3 instance under random handshakes.
module tb_mskand_rnd_feeder;

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   mskand_rnd_feeder_if #(.IN_W(2), .OUT_W(4),  .LVL_W(3)) if2 ();
   mskand_rnd_feeder_if #(.IN_W(4), .OUT_W(12), .LVL_W(3)) if3 ();

   mskand_rnd_feeder #(.d(2), .NGADGETS(4), .IN_W(2), .DEPTH(4)) u_dut2 (
      .clk  (clk),
      .nrst (nrst),
      .bus  (if2.slave)
   );

   mskand_rnd_feeder #(.d(3), .NGADGETS(4), .IN_W(4), .DEPTH(4)) u_dut3 (
      .clk  (clk),
      .nrst (nrst),
      .bus  (if3.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // d=2 reference: a word queue for the FIFO, a beat queue for the packer,
   // plus a held word when a finished word found no room.
   logic [3:0] m_fifo [$];
   logic [1:0] m_beats [$];
   bit         m_held = 1'b0;
   logic [3:0] m_hold_w = 4'h0;
   bit         m_err = 1'b0;
   bit         chk_en = 1'b0;

   initial begin
      forever begin
         @(posedge clk or negedge nrst);
         if (!nrst) begin
            m_fifo.delete();
            m_beats.delete();
            m_held = 1'b0;
            m_err  = 1'b0;
         end else begin
            bit take;
            bit room;
            logic [3:0] w;
            take = if2.out_take;
            room = (m_fifo.size() < 4) || take;
            if (take) begin
               if (m_fifo.size() > 0) void'(m_fifo.pop_front());
               else m_err = 1'b1;
            end
            if (m_held) begin
               if (room) begin
                  m_fifo.push_back(m_hold_w);
                  m_held = 1'b0;
               end
            end else if (if2.in_valid) begin
               m_beats.push_back(if2.in_rnd);
               if (m_beats.size() == 2) begin
                  w = {m_beats[1], m_beats[0]};
                  m_beats.delete();
                  if (room) m_fifo.push_back(w);
                  else begin
                     m_held   = 1'b1;
                     m_hold_w = w;
                  end
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("in_ready",  32'(if2.in_ready),      32'(nrst && !m_held));
            chk("out_valid", 32'(if2.out_valid),     32'(m_fifo.size() != 0));
            chk("level",     32'(if2.level),         32'(m_fifo.size()));
            chk("out_rnd",   32'(if2.out_rnd),       32'((m_fifo.size() != 0) ? m_fifo[0] : 4'h0));
            chk("err_uflow", 32'(if2.err_underflow), 32'(m_err));
         end
      end
   end

   // d=3 scoreboard: beats accepted in order form 12-bit words {b2,b1,b0}.
   logic [3:0]  sb_beats [$];
   logic [11:0] sb_words [$];
   int          sb_pops = 0;
   bit          sb_en = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (sb_en && nrst) begin
            if (!if3.out_valid) chk("d3_rnd_zero", 32'(if3.out_rnd), 32'h0);
            if (if3.out_take && if3.out_valid) begin
               chk("d3_sb_has_word", 32'(sb_words.size() != 0), 32'h1);
               if (sb_words.size() != 0) begin
                  chk("d3_word", 32'(if3.out_rnd), 32'(sb_words.pop_front()));
                  sb_pops++;
               end
            end
            if (if3.in_valid && if3.in_ready) begin
               sb_beats.push_back(if3.in_rnd);
               if (sb_beats.size() == 3) begin
                  sb_words.push_back({sb_beats[2], sb_beats[1], sb_beats[0]});
                  sb_beats.delete();
               end
            end
         end
      end
   end

   task automatic beat2(input logic [1:0] v);
      bit done;
      bit rdy;
      done = 1'b0;
      if2.in_rnd   = v;
      if2.in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         rdy = if2.in_ready;
         @(posedge clk);
         #1;
         done = rdy;
      end
      if (!done) chk("beat2_timeout", 32'h0, 32'h1);
      if2.in_valid = 1'b0;
   endtask

   task automatic word2(input logic [3:0] w);
      beat2(w[1:0]);
      beat2(w[3:2]);
   endtask

   task automatic take2();
      if2.out_take = 1'b1;
      @(posedge clk);
      #1;
      if2.out_take = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   logic [3:0] w2 [5];
   bit         prod_done;
   int         pops;

   initial begin
      nrst = 1'b0;
      if2.in_rnd = 2'b00; if2.in_valid = 1'b0; if2.out_take = 1'b0;
      if3.in_rnd = 4'h0;  if3.in_valid = 1'b0; if3.out_take = 1'b0;
      w2[0] = 4'h5; w2[1] = 4'hA; w2[2] = 4'h3; w2[3] = 4'hC; w2[4] = 4'h6;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(if2.in_ready),  32'h0);
      chk("rst_out_valid", 32'(if2.out_valid), 32'h0);
      chk("rst_level",     32'(if2.level),     32'h0);
      chk("rst_out_rnd",   32'(if2.out_rnd),   32'h0);
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      nrst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(if2.in_ready), 32'h1);

      // Two beats -> 4'b1001 one cycle after the second beat.
      @(posedge clk); #1;
      beat2(2'b01);
      beat2(2'b10);
      @(negedge clk);
      chk("t1_out_rnd",   32'(if2.out_rnd),   32'h9);
      chk("t1_level",     32'(if2.level),     32'h1);
      chk("t1_out_valid", 32'(if2.out_valid), 32'h1);
      @(posedge clk); #1;
      take2();

      // Five words into a depth-4 FIFO: the fifth waits in the packer.
      for (int i = 0; i < 5; i++) word2(w2[i]);
      @(negedge clk);
      chk("t2_level_full", 32'(if2.level),    32'h4);
      chk("t2_ready_held", 32'(if2.in_ready), 32'h0);
      chk("t2_head",       32'(if2.out_rnd),  32'h5);
      @(posedge clk); #1;
      take2();
      @(negedge clk);
      chk("t2_level_swap", 32'(if2.level),    32'h4);
      chk("t2_ready_back", 32'(if2.in_ready), 32'h1);
      chk("t2_head2",      32'(if2.out_rnd),  32'hA);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) take2();
      @(negedge clk);
      chk("t2_drained", 32'(if2.level), 32'h0);

      // Streaming with a consumer that takes whenever a word is presented.
      @(posedge clk); #1;
      prod_done = 1'b0;
      pops = 0;
      fork
         begin
            for (int i = 0; i < 20; i++) word2(4'(i * 7 + 3));
            prod_done = 1'b1;
         end
         begin
            for (int c = 0; c < 500 && (!prod_done || if2.out_valid); c++) begin
               @(posedge clk);
               #1;
               if2.out_take = if2.out_valid;
               if (if2.out_take) pops++;
            end
            if2.out_take = 1'b0;
         end
      join
      @(negedge clk);
      chk("t3_pops", 32'(pops), 32'd20);
      for (int i = 0; i < 4; i++) chk("t3_mem_erased", 32'(u_dut2.u_fifo.r_mem[i]), 32'h0);

      // Take while empty raises a sticky error.
      @(posedge clk); #1;
      take2();
      @(negedge clk);
      chk("t4_err",     32'(if2.err_underflow), 32'h1);
      chk("t4_level",   32'(if2.level),         32'h0);
      chk("t4_out_rnd", 32'(if2.out_rnd),       32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t4_err_sticky", 32'(if2.err_underflow), 32'h1);

      // Reset with three words buffered and a half-packed fourth.
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) word2(w2[i]);
      beat2(2'b10);
      @(negedge clk);
      chk("t5_level_pre", 32'(if2.level), 32'h3);
      @(posedge clk); #1;
      nrst = 1'b0;
      #2;
      chk("t5_rst_valid", 32'(if2.out_valid),     32'h0);
      chk("t5_rst_rnd",   32'(if2.out_rnd),       32'h0);
      chk("t5_rst_level", 32'(if2.level),         32'h0);
      chk("t5_rst_ready", 32'(if2.in_ready),      32'h0);
      chk("t5_rst_err",   32'(if2.err_underflow), 32'h0);
      @(posedge clk); #1;
      nrst = 1'b1;
      beat2(2'b11);
      beat2(2'b00);
      @(negedge clk);
      chk("t5_first_word", 32'(if2.out_rnd), 32'h3);
      chk("t5_level_post", 32'(if2.level),   32'h1);
      @(posedge clk); #1;
      take2();

      // d=3 instance with random valid gaps and random consumer stalls.
      sb_en = 1'b1;
      fork
         begin
            for (int b = 0; b < 30; b++) begin
               bit done;
               bit rdy;
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               if3.in_rnd   = 4'($urandom_range(0, 15));
               if3.in_valid = 1'b1;
               done = 1'b0;
               for (int i = 0; i < 100 && !done; i++) begin
                  @(negedge clk);
                  rdy = if3.in_ready;
                  @(posedge clk);
                  #1;
                  done = rdy;
               end
               if (!done) chk("d3_beat_timeout", 32'h0, 32'h1);
               if3.in_valid = 1'b0;
            end
         end
         begin
            for (int c = 0; c < 3000 && sb_pops < 10; c++) begin
               @(posedge clk);
               #1;
               if3.out_take = if3.out_valid && ($urandom_range(0, 1) == 1);
            end
            if3.out_take = 1'b0;
         end
      join
      @(negedge clk);
      chk("d3_pops",     32'(sb_pops),             32'd10);
      chk("d3_leftover", 32'(sb_words.size()),     32'h0);
      chk("d3_no_uflow", 32'(if3.err_underflow),   32'h0);
      chk("d3_level",    32'(if3.level),           32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
